// File: rtl/bus_sched_pkg.sv
`timescale 1ns/1ps
// bus_sched_pkg: shared types and constants for the output-bus scheduler.
// Holds the FSM state enum, bus op codes and requester indices.
package bus_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_RD     = 2'b01;
   localparam logic [1:0] OP_WR_NUM = 2'b10;
   localparam logic [1:0] OP_WR_REG = 2'b11;

   localparam int REQ_CORE = 0;
   localparam int REQ_IO   = 1;

endpackage

// File: rtl/rr_arb2.sv
`timescale 1ns/1ps
// rr_arb2: two-way arbiter returning a one-hot winner.
// Ports: req (2) request levels, ptr (1) priority pointer (1 = requester 1
// wins a tie), win (2) one-hot winner, 00 when nobody requests.
// BUS_SCHED_RR_EN defined: round-robin on ptr; otherwise requester 0 wins.
module rr_arb2
   import bus_sched_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] win
);

`ifdef BUS_SCHED_RR_EN
   always_comb begin
      win = 2'b00;
      if (req == 2'b11)
         win = ptr ? 2'b10 : 2'b01;
      else
         win = req;
   end
`else
   logic unused_ptr;
   assign unused_ptr = ptr;

   always_comb begin
      win = 2'b00;
      if (req[REQ_CORE])
         win = 2'b01;
      else if (req[REQ_IO])
         win = 2'b10;
   end
`endif

endmodule

// File: rtl/bus_sched.sv
`timescale 1ns/1ps
// bus_sched: arbitrates two requesters onto the output bus mux, drives the
// registered select for one drive cycle plus WAIT_CYCLES, then pulses done.
// Ports: clk, rst (sync, active-high), req[1:0], op0/op1[1:0] in;
// sel_outbus[1:0], gnt[1:0], done[1:0], busy out. All outputs registered.
// Optional BUS_SCHED_RR_EN macro enables round-robin arbitration.
module bus_sched
   import bus_sched_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int CW          = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] op0,
   input  logic [1:0] op1,
   output logic [1:0] sel_outbus,
   output logic [1:0] gnt,
   output logic [1:0] done,
   output logic       busy
);

   state_t          state, nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [1:0]      op_q, op_nxt;
   logic [1:0]      gnt_nxt;
   logic [1:0]      win;
   logic            ptr;

   rr_arb2 u_arb (
      .req (req),
      .ptr (ptr),
      .win (win)
   );

`ifdef BUS_SCHED_RR_EN
   // ptr high means requester 1 wins the next tie
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= 1'b0;
      else if (state == IDLE && win != 2'b00)
         ptr <= win[REQ_CORE];
   end
`else
   assign ptr = 1'b0;
`endif

   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      op_nxt  = op_q;
      gnt_nxt = gnt;
      unique case (state)
         IDLE: begin
            if (win != 2'b00) begin
               gnt_nxt = win;
               op_nxt  = win[REQ_IO] ? op1 : op0;
               nxt     = (op_nxt == OP_NOP) ? DONE : DRIVE;
            end
         end
         DRIVE: begin
            cnt_nxt = CW'(WAIT_CYCLES);
            nxt     = (WAIT_CYCLES == 0) ? DONE : HOLD;
         end
         HOLD: begin
            cnt_nxt = cnt - CW'(1);
            if (cnt == CW'(1))
               nxt = DONE;
         end
         DONE: begin
            nxt     = IDLE;
            gnt_nxt = 2'b00;
         end
         default: nxt = IDLE;
      endcase
   end

   // outputs are computed from the next state so they line up with it
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         op_q       <= OP_NOP;
         gnt        <= 2'b00;
         done       <= 2'b00;
         busy       <= 1'b0;
         sel_outbus <= OP_NOP;
      end else begin
         state      <= nxt;
         cnt        <= cnt_nxt;
         op_q       <= op_nxt;
         gnt        <= gnt_nxt;
         done       <= (nxt == DONE) ? gnt_nxt : 2'b00;
         busy       <= (nxt != IDLE);
         sel_outbus <= (nxt == DRIVE || nxt == HOLD) ? op_nxt : OP_NOP;
      end
   end

endmodule
